alu_issue_seq: RTL and testbench

- Initiator side of the ALU interface: accepts one operation request, decodes it to the 3-bit ALU control code, and drives operands into the registered ALU.
- Waits the ALU's registered latency, then captures the result and the zero flag.
- Returns a response over a valid/ready handshake.
- Sits between EX-stage decode and the ALU; also resolves BEQ/BNE from the zero flag.

---
 rtl/alu_issue_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_issue_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issues decoded ops to a registered ALU, returns response.
// Optional XOR (three-pass OR/AND/SUB) enabled by macro ALU_ISSUE_XOR_EN.
module alu_issue_seq #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_taken,
    output logic        rsp_err,
    output logic [15:0] alu_entrada1,
    output logic [15:0] alu_entrada2,
    output logic [2:0]  alu_control,
    input  logic [15:0] alu_resultado,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_BEQ = 4'b0101;
    localparam logic [3:0] OP_BNE = 4'b0110;
`ifdef ALU_ISSUE_XOR_EN
    localparam logic [3:0] OP_XOR = 4'b0111;
`endif

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // Last WAIT cycle index: the ALU output is valid during this cycle.
    localparam logic [1:0] WLAST = 2'(ALU_LATENCY - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [1:0]  pass_q;
    logic [1:0]  wcnt_q;
    logic [15:0] res_q;
    logic        zero_q;
    logic        taken_q;
    logic        err_q;

`ifdef ALU_ISSUE_XOR_EN
    logic [15:0] t1_q;
    logic [15:0] t2_q;
`endif

    logic [2:0]  pass_ctrl;
    logic [15:0] pass_e1;
    logic [15:0] pass_e2;
    logic [1:0]  last_pass;
    logic        last_wait;
    logic        final_pass;
    logic        taken_d;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB,
            OP_SLT, OP_BEQ, OP_BNE: ok = 1'b1;
`ifdef ALU_ISSUE_XOR_EN
            OP_XOR: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Per-pass ALU code and operand selection for the latched op.
    always_comb begin
        pass_ctrl = ALU_AND;
        pass_e1   = a_q;
        pass_e2   = b_q;
        case (op_q)
            OP_AND: pass_ctrl = ALU_AND;
            OP_OR:  pass_ctrl = ALU_OR;
            OP_ADD: pass_ctrl = ALU_ADD;
            OP_SUB: pass_ctrl = ALU_SUB;
            OP_SLT: pass_ctrl = ALU_SLT;
            OP_BEQ: pass_ctrl = ALU_SUB;
            OP_BNE: pass_ctrl = ALU_SUB;
`ifdef ALU_ISSUE_XOR_EN
            OP_XOR: begin
                case (pass_q)
                    2'd0: pass_ctrl = ALU_OR;
                    2'd1: pass_ctrl = ALU_AND;
                    default: begin
                        pass_ctrl = ALU_SUB;
                        pass_e1   = t1_q;
                        pass_e2   = t2_q;
                    end
                endcase
            end
`endif
            default: pass_ctrl = ALU_AND;
        endcase
    end

    // Pass bookkeeping and the branch decision from the final zero flag.
    always_comb begin
        last_pass = 2'd0;
`ifdef ALU_ISSUE_XOR_EN
        if (op_q == OP_XOR) begin
            last_pass = 2'd2;
        end
`endif
        last_wait  = (wcnt_q == WLAST);
        final_pass = (pass_q == last_pass);
        taken_d    = 1'b0;
        if (op_q == OP_BEQ) begin
            taken_d = alu_zero;
        end else if (op_q == OP_BNE) begin
            taken_d = ~alu_zero;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake / ALU drive outputs.
    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_control  = 3'b000;
        alu_entrada1 = 16'h0000;
        alu_entrada2 = 16'h0000;
        case (state_q)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid) begin
                    state_d = op_legal(req_op) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                alu_control  = pass_ctrl;
                alu_entrada1 = pass_e1;
                alu_entrada2 = pass_e2;
                state_d      = WAIT;
            end
            WAIT: begin
                alu_control  = pass_ctrl;
                alu_entrada1 = pass_e1;
                alu_entrada2 = pass_e2;
                if (last_wait) begin
                    state_d = final_pass ? DONE : ISSUE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, wait/pass counters and result capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q    <= 4'h0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            pass_q  <= 2'd0;
            wcnt_q  <= 2'd0;
            res_q   <= 16'h0000;
            zero_q  <= 1'b0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        pass_q  <= 2'd0;
                        wcnt_q  <= 2'd0;
                        res_q   <= 16'h0000;
                        zero_q  <= 1'b0;
                        taken_q <= 1'b0;
                        err_q   <= ~op_legal(req_op);
                    end
                end
                ISSUE: begin
                    wcnt_q <= 2'd0;
                end
                WAIT: begin
                    if (last_wait) begin
                        pass_q <= pass_q + 2'd1;
                        if (final_pass) begin
                            res_q   <= alu_resultado;
                            zero_q  <= alu_zero;
                            taken_q <= taken_d;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_XOR_EN
    // Temporaries for the intermediate XOR passes.
    always_ff @(posedge clock) begin
        if (reset) begin
            t1_q <= 16'h0000;
            t2_q <= 16'h0000;
        end else if (state_q == WAIT && last_wait && !final_pass) begin
            if (pass_q == 2'd0) begin
                t1_q <= alu_resultado;
            end else begin
                t2_q <= alu_resultado;
            end
        end
    end
`endif

    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_taken  = taken_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed bench for alu_issue_seq with a
// registered single-cycle ALU model.
module tb_alu_issue_seq;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_taken;
    logic        rsp_err;
    logic [15:0] alu_entrada1;
    logic [15:0] alu_entrada2;
    logic [2:0]  alu_control;
    logic [15:0] alu_resultado;
    logic        alu_zero;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_seq #(.ALU_LATENCY(1)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_zero      (rsp_zero),
        .rsp_taken     (rsp_taken),
        .rsp_err       (rsp_err),
        .alu_entrada1  (alu_entrada1),
        .alu_entrada2  (alu_entrada2),
        .alu_control   (alu_control),
        .alu_resultado (alu_resultado),
        .alu_zero      (alu_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered ALU model, one edge of latency.
    logic [15:0] alu_f;
    always_comb begin
        alu_f = 16'h0000;
        case (alu_control)
            3'b000: alu_f = alu_entrada1 & alu_entrada2;
            3'b001: alu_f = alu_entrada1 | alu_entrada2;
            3'b010: alu_f = alu_entrada1 + alu_entrada2;
            3'b011: alu_f = alu_entrada1 - alu_entrada2;
            3'b100: alu_f = {15'd0, alu_entrada1 < alu_entrada2};
            default: alu_f = 16'h0000;
        endcase
    end
    always_ff @(posedge clock) begin
        alu_resultado <= alu_f;
        alu_zero      <= (alu_f == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Issue one request; return latency (accept edge to rsp_valid)
    // and the ALU code seen in the first cycle after accept.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, output int lat,
                         output logic [2:0] ctl0);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        if (!req_ready) check("ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clock); #1;
        req_valid = 1'b0;
        ctl0 = alu_control;
        lat  = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock); #1; lat++;
        end
    endtask

    task automatic pop();
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        check("pop_valid", {31'd0, rsp_valid}, 0);
    endtask

    int         lat;
    logic [2:0] ctl0;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_a     = 16'h0;
        req_b     = 16'h0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", {31'd0, req_ready}, 0);
        check("rst_valid", {31'd0, rsp_valid}, 0);
        check("rst_ctl", {29'd0, alu_control}, 0);
        check("rst_res", {16'd0, rsp_result}, 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, req_ready}, 1);

        do_op(4'b0010, 16'h1234, 16'h0001, lat, ctl0);
        check("add_ctl", {29'd0, ctl0}, 3'b010);
        check("add_lat", lat, 3);
        check("add_res", {16'd0, rsp_result}, 16'h1235);
        check("add_zero", {31'd0, rsp_zero}, 0);
        check("add_err", {31'd0, rsp_err}, 0);
        pop();

        do_op(4'b0010, 16'hFFFF, 16'h0001, lat, ctl0);
        check("wrap_res", {16'd0, rsp_result}, 16'h0000);
        check("wrap_zero", {31'd0, rsp_zero}, 1);
        pop();

        do_op(4'b0100, 16'h0003, 16'h0005, lat, ctl0);
        check("slt_ctl", {29'd0, ctl0}, 3'b100);
        check("slt_res", {16'd0, rsp_result}, 16'h0001);
        pop();

        do_op(4'b0100, 16'hFFFF, 16'h0001, lat, ctl0);
        check("sltu_res", {16'd0, rsp_result}, 16'h0000);
        pop();

        do_op(4'b0101, 16'h00FF, 16'h00FF, lat, ctl0);
        check("beq_ctl", {29'd0, ctl0}, 3'b011);
        check("beq_taken", {31'd0, rsp_taken}, 1);
        check("beq_zero", {31'd0, rsp_zero}, 1);
        pop();

        do_op(4'b0110, 16'h00FF, 16'h00FF, lat, ctl0);
        check("bne_eq_taken", {31'd0, rsp_taken}, 0);
        pop();

        do_op(4'b0110, 16'h0001, 16'h0002, lat, ctl0);
        check("bne_taken", {31'd0, rsp_taken}, 1);
        check("bne_res", {16'd0, rsp_result}, 16'hFFFF);
        check("bne_zero", {31'd0, rsp_zero}, 0);
        pop();

        do_op(4'b0001, 16'h00F0, 16'h0F00, lat, ctl0);
        check("or_res", {16'd0, rsp_result}, 16'h0FF0);
        check("or_taken", {31'd0, rsp_taken}, 0);
        pop();

        do_op(4'b1111, 16'h1234, 16'h5678, lat, ctl0);
        check("ill_lat", lat, 1);
        check("ill_err", {31'd0, rsp_err}, 1);
        check("ill_res", {16'd0, rsp_result}, 0);
        check("ill_ctl", {29'd0, alu_control}, 0);
        pop();

`ifdef ALU_ISSUE_XOR_EN
        do_op(4'b0111, 16'hF0F0, 16'hFF00, lat, ctl0);
        check("xor_lat", lat, 7);
        check("xor_ctl0", {29'd0, ctl0}, 3'b001);
        check("xor_res", {16'd0, rsp_result}, 16'h0FF0);
        check("xor_err", {31'd0, rsp_err}, 0);
        pop();
        req_valid = 1'b1;
        req_op    = 4'b0111;
        req_a     = 16'hF0F0;
        req_b     = 16'hFF00;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("xor_seq1", {29'd0, alu_control}, 3'b001);
        repeat (2) @(posedge clock);
        #1;
        check("xor_seq2", {29'd0, alu_control}, 3'b000);
        repeat (2) @(posedge clock);
        #1;
        check("xor_seq3", {29'd0, alu_control}, 3'b011);
        check("xor_seq3_a", {16'd0, alu_entrada1}, 16'hFFF0);
        check("xor_seq3_b", {16'd0, alu_entrada2}, 16'hF000);
        repeat (2) @(posedge clock);
        #1;
        check("xor_seq_valid", {31'd0, rsp_valid}, 1);
        pop();
`else
        do_op(4'b0111, 16'hF0F0, 16'hFF00, lat, ctl0);
        check("xor_off_err", {31'd0, rsp_err}, 1);
        check("xor_off_lat", lat, 1);
        pop();
`endif

        do_op(4'b0011, 16'h0005, 16'h0003, lat, ctl0);
        check("sub_res", {16'd0, rsp_result}, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("hold_valid", {31'd0, rsp_valid}, 1);
            check("hold_res", {16'd0, rsp_result}, 16'h0002);
            check("hold_ready", {31'd0, req_ready}, 0);
        end
        pop();

        req_valid = 1'b1;
        req_op    = 4'b0010;
        req_a     = 16'h0100;
        req_b     = 16'h0200;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        check("wait_ctl", {29'd0, alu_control}, 3'b010);
        check("wait_a", {16'd0, alu_entrada1}, 16'h0100);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_rst_ready", {31'd0, req_ready}, 0);
        check("mid_rst_valid", {31'd0, rsp_valid}, 0);
        check("mid_rst_ctl", {29'd0, alu_control}, 0);
        check("mid_rst_e1", {16'd0, alu_entrada1}, 0);
        check("mid_rst_e2", {16'd0, alu_entrada2}, 0);
        check("mid_rst_flags",
              {28'd0, rsp_zero, rsp_taken, rsp_err, 1'b0}, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_idle", {31'd0, req_ready}, 1);
        @(posedge clock); #1;
        check("mid_rst_stay", {31'd0, rsp_valid}, 0);

        do_op(4'b0010, 16'h0002, 16'h0003, lat, ctl0);
        check("after_rst_lat", lat, 3);
        check("after_rst_res", {16'd0, rsp_result}, 16'h0005);
        pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
